unidade_controle_multiciclo: RTL
================================

// Module: unidade_controle_multiciclo
// PURPOSE
//  Multicycle control FSM for the 8-bit CPU. Sequences fetch/decode/execute/writeback.
//  Drives the datapath enables and the 2-bit Controle_ALUop consumed by the ALU.
//  Takes the ALU zero flag back for BEQ. Sits between instruction memory/IR and the datapath.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles waiting for mem_ready in any memory state; 0 = no timeout
// PORTS
//  clk             in   1  single clock, all state changes on rising edge
//  rst_n           in   1  synchronous, active-low reset
//  opcode          in   4  IR[7:4], stable from DECODE until next FETCH
//  zero            in   1  ALU zero flag (ALU output, combinational)
//  mem_ready       in   1  memory completes the current request this cycle
//  mem_req         out  1  memory request, held until mem_ready
//  mem_we          out  1  1 = write (SW only)
//  addr_sel        out  1  memory address: 0 = PC, 1 = immediate register
//  ir_we           out  1  load IR from memory data
//  imm_we          out  1  load immediate register from memory data
//  mdr_we          out  1  load memory data register (LW)
//  pc_inc          out  1  PC <= PC + 1
//  pc_load         out  1  PC <= immediate
//  Controle_ALUop  out  2  00 add, 01 sub, 10 and, 11 or
//  reg_we          out  1  register file write to rd
//  wb_sel          out  1  write-back source: 0 = ALU result, 1 = MDR
//  halted          out  1  CPU stopped
//  bus_err         out  1  memory timeout occurred (sticky until reset)
// BEHAVIOUR
//  - Opcodes: 0000-0011 R-type (ALUop = opcode[1:0]); 0100 LW; 0101 SW; 0110 BEQ; 0111 J;
//    1111 HALT; any other opcode = NOP.
//  - LW/SW/BEQ/J take a second byte (immediate) at PC.
//  - Reset: while rst_n=0 at a rising edge, state <= IDLE, timeout counter <= 0, bus_err <= 0.
//    Every output is 0 in IDLE. IDLE -> FETCH on the next cycle unconditionally.
//  - Reset mid-operation: an in-flight request is abandoned; mem_req is 0 in the cycle after the reset edge.
//  - Moore outputs come from the state. ir_we, imm_we, mdr_we and pc_inc are qualified by mem_ready (Mealy).
//  - Unlisted outputs are 0; ALUop defaults to 00.
//  FETCH     mem_req=1, addr_sel=0. On mem_ready: ir_we=1, pc_inc=1 -> DECODE.
//  DECODE    R-type -> EXEC. LW/SW/BEQ/J -> FETCH_IMM. HALT -> HALT. Other -> FETCH.
//  FETCH_IMM mem_req=1, addr_sel=0. On mem_ready: imm_we=1, pc_inc=1.
//            Next state: LW -> MEM_RD, SW -> MEM_WR, BEQ -> BRANCH, J -> JUMP.
//  EXEC      ALUop=opcode[1:0] -> WB_ALU.
//  WB_ALU    ALUop held, reg_we=1, wb_sel=0 -> FETCH.
//  MEM_RD    mem_req=1, addr_sel=1. On mem_ready: mdr_we=1 -> WB_MEM.
//  WB_MEM    reg_we=1, wb_sel=1 -> FETCH.
//  MEM_WR    mem_req=1, mem_we=1, addr_sel=1. On mem_ready -> FETCH.
//  BRANCH    ALUop=01. pc_load = zero. -> FETCH.
//  JUMP      pc_load=1 -> FETCH.
//  HALT      halted=1, absorbing; only rst_n leaves it.
//  - Latency with zero-wait memory (mem_ready high on the first request cycle):
//    R-type 4 cycles, LW 5, SW/BEQ/J 4, NOP 2 (FETCH..FETCH).
//  - Each wait cycle adds one cycle.
//  - Timeout counter: cleared on entry to any memory state; increments each cycle mem_req=1 and mem_ready=0.
//    If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT: next state HALT, bus_err <= 1.
//    A mem_ready in that same cycle wins (no error).
//  - opcode is sampled only in DECODE, FETCH_IMM, EXEC, WB_ALU and BRANCH. No other state reacts to it.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles -> all outputs 0. First cycle after release: IDLE, outputs 0. Next cycle: mem_req=1.
//  2. ADD/OR, mem_ready=1: opcode=0000 -> EXEC/WB_ALU ALUop=00, reg_we in cycle 4.
//     opcode=0011 -> ALUop=11. Back in FETCH at cycle 5.
//  3. LW with 3 wait cycles in MEM_RD: mdr_we pulses once, on the mem_ready cycle.
//     Then reg_we=1, wb_sel=1. Total 8 cycles.
//  4. BEQ: zero=1 -> pc_load=1 with ALUop=01. zero=0 -> pc_load=0 and the next state is FETCH.
//  5. Timeout, MEM_TIMEOUT=15: hold mem_ready=0 in FETCH -> after 15 wait cycles state=HALT, bus_err=1, halted=1.
//     mem_ready at wait 15 -> no error.
//  6. HALT opcode -> halted stays 1 for 100 cycles. Assert rst_n=0 mid-MEM_WR -> mem_req=0 the next cycle.

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the 8-bit CPU: fetch/decode/execute/writeback sequencing,
// datapath enables, ALU op select and a memory-wait watchdog that halts on timeout.
module unidade_controle_multiciclo #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       imm_we,
  output logic       mdr_we,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [1:0] Controle_ALUop,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       halted,
  output logic       bus_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH_IMM, S_EXEC, S_WB_ALU,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          berr_q, berr_d;
  logic          mem_wait;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tmo_d          = tmo_q;
    berr_d         = berr_q;
    mem_wait       = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    addr_sel       = 1'b0;
    ir_we          = 1'b0;
    imm_we         = 1'b0;
    mdr_we         = 1'b0;
    pc_inc         = 1'b0;
    pc_load        = 1'b0;
    Controle_ALUop = 2'b00;
    reg_we         = 1'b0;
    wb_sel         = 1'b0;
    halted         = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else mem_wait = 1'b1;
      end
      S_DECODE: begin
        casez (opcode)
          4'b00??: state_d = S_EXEC;
          4'b01??: state_d = S_FETCH_IMM;
          4'b1111: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          imm_we = 1'b1;
          pc_inc = 1'b1;
          // Only 01xx opcodes reach here, so the low bits pick the follow-up.
          case (opcode[1:0])
            2'b00:   state_d = S_MEM_RD;
            2'b01:   state_d = S_MEM_WR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_JUMP;
          endcase
        end else mem_wait = 1'b1;
      end
      S_EXEC: begin
        Controle_ALUop = opcode[1:0];
        state_d        = S_WB_ALU;
      end
      S_WB_ALU: begin
        Controle_ALUop = opcode[1:0];
        reg_we         = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          mdr_we  = 1'b1;
          state_d = S_WB_MEM;
        end else mem_wait = 1'b1;
      end
      S_WB_MEM: begin
        reg_we  = 1'b1;
        wb_sel  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_d = S_FETCH;
        else mem_wait = 1'b1;
      end
      S_BRANCH: begin
        Controle_ALUop = 2'b01;
        pc_load        = zero;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        pc_load = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // The wait that would bring the counter to MEM_TIMEOUT trips the watchdog;
    // a mem_ready in that cycle means no wait, so it wins.
    if (mem_wait) begin
      if (MEM_TIMEOUT != 0 && int'(tmo_q) == MEM_TIMEOUT - 1) begin
        state_d = S_HALT;
        berr_d  = 1'b1;
      end else tmo_d = tmo_q + 1'b1;
    end
    if (state_d != state_q) tmo_d = '0;
  end

  assign bus_err = berr_q;

endmodule
